// File: rtl/dmi_boot_sequencer.sv
// On-chip boot sequencer: halts hart 0 over DMI, programs DPC with the entry
// point, resumes the hart, then polls an EOC word over system-bus access.
module dmi_boot_sequencer #(
    parameter int unsigned MaxPolls   = 1024,
    parameter int unsigned PollGap    = 16,
    parameter logic [31:0] EocAddr    = 32'h0000_0000,
    parameter int unsigned EocTimeout = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] entry_point_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  err_code_o,
    output logic [31:0] exit_status_o
);

    localparam int unsigned PollW = $clog2(MaxPolls + 1);
    localparam int unsigned GapW  = $clog2(PollGap + 1);
    localparam int unsigned EocW  = (EocTimeout == 0) ? 1 : $clog2(EocTimeout + 1);

    localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(PollGap - 1);
    localparam logic [EocW-1:0]  EocLast  = EocW'(EocTimeout - 1);

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;

    typedef enum logic [3:0] {
        StIdle, StAct, StHalt, StPhalt, StData, StCmd, StPabs,
        StRes, StPres, StSbcs, StSba, StPeoc, StGap
    } state_e;

    state_e            state_q, state_d;
    logic              wait_resp_q, wait_resp_d;
    logic [31:0]       entry_q, entry_d;
    logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [EocW-1:0]   eoc_cnt_q, eoc_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [2:0]        err_code_q, err_code_d;
    logic [31:0]       exit_status_q, exit_status_d;
    logic [2:0]        fail_code;
    logic              req_fire;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            wait_resp_q   <= 1'b0;
            entry_q       <= '0;
            poll_cnt_q    <= '0;
            eoc_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
            exit_status_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_resp_q   <= wait_resp_d;
            entry_q       <= entry_d;
            poll_cnt_q    <= poll_cnt_d;
            eoc_cnt_q     <= eoc_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            exit_status_q <= exit_status_d;
        end
    end

    assign req_fire = dmi_req_valid_o & dmi_req_ready_i;

    // Each step state issues its request, then waits for the response;
    // clearing wait_resp while staying in a poll state re-issues the read.
    always_comb begin
        state_d       = state_q;
        wait_resp_d   = wait_resp_q;
        entry_d       = entry_q;
        poll_cnt_d    = poll_cnt_q;
        eoc_cnt_d     = eoc_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        exit_status_d = exit_status_q;
        fail_code     = 3'd0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    entry_d       = entry_point_i;
                    done_d        = 1'b0;
                    error_d       = 1'b0;
                    err_code_d    = 3'd0;
                    exit_status_d = '0;
                    busy_d        = 1'b1;
                    poll_cnt_d    = '0;
                    eoc_cnt_d     = '0;
                    gap_cnt_d     = '0;
                    wait_resp_d   = 1'b0;
                    state_d       = StAct;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    gap_cnt_d = '0;
                    state_d   = StSba;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                if (!wait_resp_q) begin
                    if (req_fire) begin
                        wait_resp_d = 1'b1;
                    end
                end else if (dmi_resp_valid_i) begin
                    wait_resp_d = 1'b0;
                    if (dmi_resp_resp_i != 2'd0) begin
                        fail_code = 3'd1;
                    end else begin
                        case (state_q)
                            StAct:  state_d = StHalt;
                            StHalt: begin
                                poll_cnt_d = '0;
                                state_d    = StPhalt;
                            end
                            StPhalt: begin
                                if (dmi_resp_data_i[9])          state_d    = StData;
                                else if (poll_cnt_q == PollLast) fail_code  = 3'd2;
                                else                             poll_cnt_d = poll_cnt_q + 1'b1;
                            end
                            StData: state_d = StCmd;
                            StCmd: begin
                                poll_cnt_d = '0;
                                state_d    = StPabs;
                            end
                            StPabs: begin
                                if (dmi_resp_data_i[10:8] != 3'd0) fail_code  = 3'd3;
                                else if (!dmi_resp_data_i[12])     state_d    = StRes;
                                else if (poll_cnt_q == PollLast)   fail_code  = 3'd4;
                                else                               poll_cnt_d = poll_cnt_q + 1'b1;
                            end
                            StRes: begin
                                poll_cnt_d = '0;
                                state_d    = StPres;
                            end
                            StPres: begin
                                if (dmi_resp_data_i[17]) begin
                                    eoc_cnt_d = '0;
                                    state_d   = StSbcs;
                                end else if (poll_cnt_q == PollLast) begin
                                    fail_code = 3'd5;
                                end else begin
                                    poll_cnt_d = poll_cnt_q + 1'b1;
                                end
                            end
                            StSbcs: state_d = StSba;
                            StSba:  state_d = StPeoc;
                            StPeoc: begin
                                if (dmi_resp_data_i[31]) begin
                                    exit_status_d = {1'b0, dmi_resp_data_i[30:0]};
                                    done_d        = 1'b1;
                                    busy_d        = 1'b0;
                                    state_d       = StIdle;
                                end else if (EocTimeout != 0 && eoc_cnt_q == EocLast) begin
                                    fail_code = 3'd6;
                                end else begin
                                    eoc_cnt_d = eoc_cnt_q + 1'b1;
                                    gap_cnt_d = '0;
                                    state_d   = StGap;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (fail_code != 3'd0) begin
            state_d     = StIdle;
            wait_resp_d = 1'b0;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_code_d  = fail_code;
        end
    end

    // Request fields depend only on the state, so they stay stable under backpressure.
    always_comb begin
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        dmi_req_addr_o   = 7'h00;
        dmi_req_op_o     = 2'd0;
        dmi_req_data_o   = 32'h0;
        if (state_q != StIdle && state_q != StGap) begin
            dmi_req_valid_o  = !wait_resp_q;
            dmi_resp_ready_o = wait_resp_q;
        end
        case (state_q)
            StAct:   begin dmi_req_addr_o = 7'h10; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h0000_0001; end
            StHalt:  begin dmi_req_addr_o = 7'h10; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h8000_0001; end
            StPhalt: begin dmi_req_addr_o = 7'h11; dmi_req_op_o = OpRead; end
            StData:  begin dmi_req_addr_o = 7'h04; dmi_req_op_o = OpWrite; dmi_req_data_o = entry_q; end
            StCmd:   begin dmi_req_addr_o = 7'h17; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h0023_07B1; end
            StPabs:  begin dmi_req_addr_o = 7'h16; dmi_req_op_o = OpRead; end
            StRes:   begin dmi_req_addr_o = 7'h10; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h4000_0001; end
            StPres:  begin dmi_req_addr_o = 7'h11; dmi_req_op_o = OpRead; end
            StSbcs:  begin dmi_req_addr_o = 7'h38; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h0014_0000; end
            StSba:   begin dmi_req_addr_o = 7'h39; dmi_req_op_o = OpWrite; dmi_req_data_o = EocAddr; end
            StPeoc:  begin dmi_req_addr_o = 7'h3C; dmi_req_op_o = OpRead; end
            default: ;
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign err_code_o    = err_code_q;
    assign exit_status_o = exit_status_q;

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Scoreboard bench for dmi_boot_sequencer: a behavioural debug-module model
// answers DMI requests; monitors compare requests and final results to queues.
module tb_dmi_boot_sequencer;

    localparam int unsigned MaxPolls   = 8;
    localparam int unsigned PollGap    = 4;
    localparam logic [31:0] EocAddr    = 32'h1000_0FF0;
    localparam int unsigned EocTimeout = 20;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] entry_point_i;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [6:0]  dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0]  dmi_resp_resp_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [2:0]  err_code_o;
    logic [31:0] exit_status_o;

    dmi_boot_sequencer #(
        .MaxPolls  (MaxPolls),
        .PollGap   (PollGap),
        .EocAddr   (EocAddr),
        .EocTimeout(EocTimeout)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .entry_point_i   (entry_point_i),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_req_addr_o  (dmi_req_addr_o),
        .dmi_req_op_o    (dmi_req_op_o),
        .dmi_req_data_o  (dmi_req_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i (dmi_resp_data_i),
        .dmi_resp_resp_i (dmi_resp_resp_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_code_o      (err_code_o),
        .exit_status_o   (exit_status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [40:0] exp_req[$];
    logic [36:0] exp_end[$];

    // Debug-module model configuration and state
    int          halt_after, abs_after, resume_after, eoc_after, ready_delay;
    bit          abs_err, fast_resp, resumed, stall_en;
    logic [6:0]  stall_addr;
    logic [31:0] eoc_word;
    int          halt_reads, abs_reads, resume_reads, eoc_reads, stall_cnt;
    int          late_cnt = 0;
    bit          pend_resp, accept_pending;
    logic [31:0] pend_data;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic configModel(input int h, input int a, input bit aerr, input int r,
                               input int e, input logic [31:0] w, input int dly, input bit fast);
        halt_after = h; abs_after = a; abs_err = aerr; resume_after = r;
        eoc_after = e; eoc_word = w; ready_delay = dly; fast_resp = fast;
        halt_reads = 0; abs_reads = 0; resume_reads = 0; eoc_reads = 0;
        resumed = 0; stall_cnt = 0; stall_en = 0; stall_addr = 7'h00;
    endtask

    task automatic pushReq(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        exp_req.push_back({a, op, d});
    endtask

    task automatic pushPolls(input logic [6:0] a, input int n);
        for (int i = 0; i < n; i++) pushReq(a, 2'd1, 32'h0);
    endtask

    task automatic pushFront(input logic [31:0] entry, input int halt_n);
        pushReq(7'h10, 2'd2, 32'h0000_0001);
        pushReq(7'h10, 2'd2, 32'h8000_0001);
        pushPolls(7'h11, halt_n);
        pushReq(7'h04, 2'd2, entry);
        pushReq(7'h17, 2'd2, 32'h0023_07B1);
    endtask

    task automatic pushNominal(input logic [31:0] entry, input int halt_n, input int abs_n,
                               input int res_n, input int eoc_n);
        pushFront(entry, halt_n);
        pushPolls(7'h16, abs_n);
        pushReq(7'h10, 2'd2, 32'h4000_0001);
        pushPolls(7'h11, res_n);
        pushReq(7'h38, 2'd2, 32'h0014_0000);
        for (int i = 0; i < eoc_n; i++) begin
            pushReq(7'h39, 2'd2, EocAddr);
            pushReq(7'h3C, 2'd1, 32'h0);
        end
    endtask

    task automatic dmServe(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                           output logic [31:0] rdata);
        rdata = 32'h0;
        if (op == 2'd1) begin
            case (a)
                7'h11: begin
                    if (!resumed) begin
                        halt_reads++;
                        if (halt_reads >= halt_after) rdata[9] = 1'b1;
                    end else begin
                        resume_reads++;
                        rdata[9] = 1'b1;
                        if (resume_reads >= resume_after) rdata[17] = 1'b1;
                    end
                end
                7'h16: begin
                    if (abs_err) rdata = 32'h0000_0200;
                    else begin
                        abs_reads++;
                        if (abs_reads < abs_after) rdata[12] = 1'b1;
                    end
                end
                7'h3C: begin
                    eoc_reads++;
                    if (eoc_reads >= eoc_after) rdata = eoc_word;
                end
                default: ;
            endcase
        end else if (op == 2'd2 && a == 7'h10 && d == 32'h4000_0001) begin
            resumed = 1'b1;
        end
    endtask

    // Debug-module model: drives ready/response on the negative edge
    initial begin
        logic [31:0] rd;
        dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i = 32'h0; dmi_resp_resp_i = 2'd0;
        pend_resp = 1'b0; accept_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
                pend_resp = 1'b0; accept_pending = 1'b0; stall_cnt = 0;
            end else if (late_cnt > 0) begin
                late_cnt--;
                dmi_req_ready_i  = 1'b0;
                dmi_resp_valid_i = (late_cnt != 0);
                dmi_resp_data_i  = 32'h8000_0055;
                dmi_resp_resp_i  = 2'd0;
            end else begin
                if (accept_pending) begin
                    dmi_resp_valid_i = 1'b0;
                    accept_pending = 1'b0;
                end
                if (pend_resp && !dmi_resp_valid_i) begin
                    dmi_resp_valid_i = 1'b1;
                    dmi_resp_data_i  = pend_data;
                    pend_resp = 1'b0;
                end
                dmi_req_ready_i = 1'b0;
                if (dmi_req_valid_o) begin
                    if (stall_en && dmi_req_addr_o == stall_addr) begin
                        dmi_req_ready_i = 1'b0;
                    end else if (stall_cnt < ready_delay) begin
                        stall_cnt++;
                    end else begin
                        dmi_req_ready_i = 1'b1;
                        stall_cnt = 0;
                        dmServe(dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, rd);
                        if (fast_resp && !dmi_resp_valid_i) begin
                            dmi_resp_valid_i = 1'b1;
                            dmi_resp_data_i  = rd;
                        end else begin
                            pend_resp = 1'b1;
                            pend_data = rd;
                        end
                    end
                end
                if (dmi_resp_valid_i && dmi_resp_ready_o) accept_pending = 1'b1;
            end
        end
    end

    // Request monitor: pops an expected request on every accepted handshake
    initial begin
        logic [40:0] fields, held, e;
        bit in_hold, unstable;
        in_hold = 0; unstable = 0; held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni) begin
                in_hold = 0; unstable = 0;
            end else if (dmi_req_valid_o) begin
                fields = {dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o};
                if (!in_hold) begin
                    held = fields; in_hold = 1;
                end else if (fields != held) begin
                    unstable = 1;
                end
                if (dmi_req_ready_i) begin
                    if (exp_req.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("[TB] FAIL unexpected_req: actual=%0h required=none", fields);
                    end else begin
                        e = exp_req.pop_front();
                        checkOutput("dmi_req", 64'(fields), 64'(e));
                        checkOutput("req_stable", 64'(unstable), 64'd0);
                    end
                    in_hold = 0; unstable = 0;
                end
            end
        end
    end

    // Result monitor: compares status outputs whenever busy falls
    initial begin
        logic prev_busy;
        logic [36:0] e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_busy && !busy_o) begin
                if (exp_end.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL unexpected_end: actual=%0h required=none",
                             {done_o, error_o, err_code_o, exit_status_o});
                end else begin
                    e = exp_end.pop_front();
                    checkOutput("result", 64'({done_o, error_o, err_code_o, exit_status_o}), 64'(e));
                end
            end
            prev_busy = busy_o;
        end
    end

    task automatic launch(input string name, input logic [31:0] entry);
        checkOutput({name, "_idle_before"}, 64'(busy_o), 64'd0);
        start_i = 1'b1;
        entry_point_i = entry;
        tick();
        start_i = 1'b0;
        entry_point_i = 32'hFFFF_FFFF;
        checkOutput({name, "_busy_after_start"}, 64'(busy_o), 64'd1);
        checkOutput({name, "_flags_cleared"}, 64'({done_o, error_o, err_code_o}), 64'd0);
    endtask

    task automatic drainCheck(input string name);
        tick(); tick();
        checkOutput({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
        checkOutput({name, "_end_left"}, 64'(exp_end.size()), 64'd0);
        exp_req.delete();
        exp_end.delete();
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] entry);
        int n;
        launch(name, entry);
        n = 0;
        while (busy_o && n < 4000) begin
            tick();
            n++;
        end
        if (busy_o) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy_o, n);
        end
        drainCheck(name);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; start_i = 1'b0; entry_point_i = 32'h0;
        configModel(1, 1, 0, 1, 1, 32'h8000_0000, 0, 0);
        repeat (3) tick();
        checkOutput("rst_status", 64'({busy_o, done_o, error_o, err_code_o, exit_status_o}), 64'd0);
        checkOutput("rst_req", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}), 64'd0);
        checkOutput("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        $display("[TB] nominal boot");
        configModel(3, 2, 0, 1, 5, 32'h8000_0000, 0, 0);
        pushNominal(32'h1C00_0080, 3, 2, 1, 5);
        exp_end.push_back({1'b1, 1'b0, 3'd0, 32'd0});
        applyStimulus("nominal", 32'h1C00_0080);

        $display("[TB] exit code with same-cycle response");
        configModel(1, 1, 0, 1, 1, 32'h8000_0007, 0, 1);
        pushNominal(32'h0000_1000, 1, 1, 1, 1);
        exp_end.push_back({1'b1, 1'b0, 3'd0, 32'd7});
        applyStimulus("exit_code", 32'h0000_1000);

        $display("[TB] halt timeout");
        configModel(1000, 1, 0, 1, 1, 32'h8000_0000, 0, 0);
        pushReq(7'h10, 2'd2, 32'h0000_0001);
        pushReq(7'h10, 2'd2, 32'h8000_0001);
        pushPolls(7'h11, 8);
        exp_end.push_back({1'b0, 1'b1, 3'd2, 32'd0});
        applyStimulus("halt_timeout", 32'h2000_0000);

        $display("[TB] cmderr");
        configModel(1, 1, 1, 1, 1, 32'h8000_0000, 0, 0);
        pushFront(32'h3000_0004, 1);
        pushPolls(7'h16, 1);
        exp_end.push_back({1'b0, 1'b1, 3'd3, 32'd0});
        applyStimulus("cmderr", 32'h3000_0004);

        $display("[TB] backpressure");
        configModel(3, 2, 0, 1, 5, 32'h8000_0000, 4, 0);
        pushNominal(32'h1C00_0080, 3, 2, 1, 5);
        exp_end.push_back({1'b1, 1'b0, 3'd0, 32'd0});
        applyStimulus("backpressure", 32'h1C00_0080);

        $display("[TB] EOC timeout");
        configModel(1, 1, 0, 1, 100000, 32'h8000_0000, 0, 0);
        pushNominal(32'h0000_0400, 1, 1, 1, 20);
        exp_end.push_back({1'b0, 1'b1, 3'd6, 32'd0});
        applyStimulus("eoc_timeout", 32'h0000_0400);

        $display("[TB] reset during CMD write");
        configModel(1, 1, 0, 1, 5, 32'h8000_0000, 0, 0);
        stall_en = 1'b1;
        stall_addr = 7'h17;
        pushFront(32'h1C00_0080, 1);
        void'(exp_req.pop_back());
        exp_end.push_back({1'b0, 1'b0, 3'd0, 32'd0});
        launch("reset_mid", 32'h1C00_0080);
        n = 0;
        while (!(dmi_req_valid_o && dmi_req_addr_o == 7'h17) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("reset_mid_cmd_pending", 64'(dmi_req_valid_o && dmi_req_addr_o == 7'h17), 64'd1);
        tick(); tick();
        rst_ni = 1'b0;
        tick();
        checkOutput("reset_mid_status", 64'({busy_o, done_o, error_o, err_code_o, exit_status_o}), 64'd0);
        checkOutput("reset_mid_req", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o}), 64'd0);
        tick();
        rst_ni = 1'b1;
        stall_en = 1'b0;
        late_cnt = 4;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("late_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
            checkOutput("late_status", 64'({busy_o, done_o, error_o, exit_status_o}), 64'd0);
        end
        drainCheck("reset_mid");

        configModel(3, 2, 0, 1, 5, 32'h8000_0000, 0, 0);
        pushNominal(32'h1C00_0080, 3, 2, 1, 5);
        exp_end.push_back({1'b1, 1'b0, 3'd0, 32'd0});
        applyStimulus("after_reset", 32'h1C00_0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
